// File: rtl/isp_pkg.sv
// Shared types and helpers for the raw Bayer test-pattern generator.
// Holds the FSM encoding, pattern/CFA constants and colour-bar lookups.
package isp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBLANK = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4
  } tpg_state_e;

  localparam logic [1:0] PAT_FLAT  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_CHECK = 2'd3;

  localparam int BAYER_RGGB = 0;
  localparam int BAYER_GRBG = 1;
  localparam int BAYER_GBRG = 2;
  localparam int BAYER_BGGR = 3;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } cfa_chan_e;

  // Colour channel sampled at a site, from CFA order and (row, column) parity.
  function automatic cfa_chan_e cfa_channel(input int bayer, input logic row_odd, input logic col_odd);
    cfa_chan_e ch;
    logic [1:0] par;
    par = {row_odd, col_odd};
    ch  = CH_G;
    case (bayer)
      BAYER_RGGB: begin
        case (par)
          2'b00:   ch = CH_R;
          2'b11:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
      BAYER_GRBG: begin
        case (par)
          2'b01:   ch = CH_R;
          2'b10:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
      BAYER_GBRG: begin
        case (par)
          2'b10:   ch = CH_R;
          2'b01:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
      default: begin
        case (par)
          2'b11:   ch = CH_R;
          2'b00:   ch = CH_B;
          default: ch = CH_G;
        endcase
      end
    endcase
    return ch;
  endfunction

  // {R,G,B} on/off for bars: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/isp_tpg_pattern.sv
// Combinational pixel generator: maps (x, y, bar index, mode) to one Bayer sample.
module isp_tpg_pattern
  import isp_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int BAYER = 3
) (
  input  logic [1:0]      mode,
  input  logic [BITS-1:0] flat_value,
  input  logic [15:0]     x,
  input  logic [15:0]     y,
  input  logic [2:0]      bar_idx,
  input  logic            frame_odd,
  output logic [BITS-1:0] pixel
);

  localparam logic [BITS-1:0] FULL_SCALE = {BITS{1'b1}};
  localparam logic [BITS-1:0] ZERO       = {BITS{1'b0}};

  logic [2:0] rgb_s;
  cfa_chan_e  chan_s;
  logic       bar_on_s;
  logic       unused_s;

  assign unused_s = ^{x, y};

  // Select the pattern sample for the current site.
  always_comb begin
    rgb_s    = bar_rgb(bar_idx);
    chan_s   = cfa_channel(BAYER, y[0], x[0]);
    bar_on_s = 1'b0;
    case (chan_s)
      CH_R:    bar_on_s = rgb_s[2];
      CH_G:    bar_on_s = rgb_s[1];
      CH_B:    bar_on_s = rgb_s[0];
      default: bar_on_s = 1'b0;
    endcase

    pixel = ZERO;
    case (mode)
      PAT_FLAT:  pixel = flat_value;
      PAT_RAMP:  pixel = BITS'(x);
      PAT_BARS:  pixel = bar_on_s ? FULL_SCALE : ZERO;
      PAT_CHECK: pixel = (x[3] ^ y[3] ^ frame_odd) ? FULL_SCALE : ZERO;
      default:   pixel = ZERO;
    endcase
  end

endmodule

// File: rtl/isp_raw_tpg.sv
// Raw Bayer test-pattern source with vsync/href timing, frame counting and
// frame-boundary run control. All outputs are registered from the next state.
module isp_raw_tpg
  import isp_pkg::*;
#(
  parameter int BITS     = 8,
  parameter int WIDTH    = 1920,
  parameter int HEIGHT   = 1080,
  parameter int H_BLANK  = 5,
  parameter int V_BLANK  = 2,
  parameter int VS_LINES = 1,
  parameter int BAYER    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      pattern_mode,
  input  logic [BITS-1:0] flat_value,
  output logic            out_vsync,
  output logic            out_href,
  output logic [BITS-1:0] out_raw,
  output logic            busy,
  output logic            frame_done,
  output logic [15:0]     frame_cnt
);

  localparam int          LINE     = WIDTH + H_BLANK;
  localparam logic [15:0] COL_LAST = 16'(LINE - 1);
  localparam logic [15:0] ACT_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(HEIGHT - 1);
  localparam logic [15:0] VS_LAST  = 16'(VS_LINES - 1);
  localparam logic [15:0] VB_LAST  = (V_BLANK > 0) ? 16'(V_BLANK - 1) : 16'd0;
  localparam logic [15:0] BAR_LAST = 16'(WIDTH / 8 - 1);

  tpg_state_e      state_q, state_d;
  logic [15:0]     col_q, col_d;
  logic [15:0]     vline_q, vline_d;
  logic [15:0]     x_q, x_d;
  logic [15:0]     y_q, y_d;
  logic [15:0]     bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [BITS-1:0] flat_q, flat_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            out_vsync_q, out_vsync_d;
  logic            out_href_q, out_href_d;
  logic [BITS-1:0] out_raw_q, out_raw_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            line_end_s, frame_end_s, start_s;
  logic [BITS-1:0] pix_s;

  // State, counters and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= 16'd0;
      vline_q      <= 16'd0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      bar_cnt_q    <= 16'd0;
      bar_idx_q    <= 3'd0;
      mode_q       <= 2'd0;
      flat_q       <= {BITS{1'b0}};
      frame_cnt_q  <= 16'd0;
      out_vsync_q  <= 1'b0;
      out_href_q   <= 1'b0;
      out_raw_q    <= {BITS{1'b0}};
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      vline_q      <= vline_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_cnt_q    <= bar_cnt_d;
      bar_idx_q    <= bar_idx_d;
      mode_q       <= mode_d;
      flat_q       <= flat_d;
      frame_cnt_q  <= frame_cnt_d;
      out_vsync_q  <= out_vsync_d;
      out_href_q   <= out_href_d;
      out_raw_q    <= out_raw_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state and counters; col counts clocks within every non-idle line.
  always_comb begin
    line_end_s  = (col_q == COL_LAST);
    frame_end_s = (state_q == ST_HBLANK) && line_end_s && (y_q == ROW_LAST);
    state_d     = state_q;
    col_d       = col_q;
    vline_d     = vline_q;
    x_d         = 16'd0;
    y_d         = y_q;
    bar_cnt_d   = 16'd0;
    bar_idx_d   = 3'd0;
    frame_cnt_d = frame_cnt_q;
    start_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        col_d   = 16'd0;
        vline_d = 16'd0;
        y_d     = 16'd0;
        if (enable) begin
          state_d = ST_VSYNC;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        y_d = 16'd0;
        if (line_end_s) begin
          col_d = 16'd0;
          if (vline_q == VS_LAST) begin
            vline_d = 16'd0;
            state_d = (V_BLANK == 0) ? ST_ACTIVE : ST_VBLANK;
          end else begin
            vline_d = vline_q + 16'd1;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      ST_VBLANK: begin
        y_d = 16'd0;
        if (line_end_s) begin
          col_d = 16'd0;
          if (vline_q == VB_LAST) begin
            vline_d = 16'd0;
            state_d = ST_ACTIVE;
          end else begin
            vline_d = vline_q + 16'd1;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      ST_ACTIVE: begin
        col_d = col_q + 16'd1;
        if (col_q == ACT_LAST) begin
          state_d = ST_HBLANK;
        end else begin
          x_d = x_q + 16'd1;
          // Bar index steps on a per-bar pixel counter instead of dividing x.
          if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_d = 16'd0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
            bar_idx_d = bar_idx_q;
          end
        end
      end
      ST_HBLANK: begin
        if (line_end_s) begin
          col_d = 16'd0;
          if (y_q == ROW_LAST) begin
            y_d         = 16'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (enable) begin
              state_d = ST_VSYNC;
              start_s = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            y_d     = y_q + 16'd1;
            state_d = ST_ACTIVE;
          end
        end else begin
          col_d = col_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = 16'd0;
        vline_d = 16'd0;
        y_d     = 16'd0;
      end
    endcase

    if (start_s) begin
      mode_d = pattern_mode;
      flat_d = flat_value;
    end else begin
      mode_d = mode_q;
      flat_d = flat_q;
    end
  end

  isp_tpg_pattern #(
    .BITS  (BITS),
    .BAYER (BAYER)
  ) u_pattern (
    .mode       (mode_q),
    .flat_value (flat_q),
    .x          (x_d),
    .y          (y_d),
    .bar_idx    (bar_idx_d),
    .frame_odd  (frame_cnt_q[0]),
    .pixel      (pix_s)
  );

  // Outputs decoded from the next state so they line up with the registered state.
  always_comb begin
    out_vsync_d  = (state_d == ST_VSYNC);
    out_href_d   = (state_d == ST_ACTIVE);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = frame_end_s;
    if (state_d == ST_ACTIVE) begin
      out_raw_d = pix_s;
    end else begin
      out_raw_d = {BITS{1'b0}};
    end
  end

  assign out_vsync  = out_vsync_q;
  assign out_href   = out_href_q;
  assign out_raw    = out_raw_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
